// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// The access-error rule lives here so the core and any monitor agree on it.
package mips_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  // A word access is bad when it is not word aligned or falls past the last word.
  function automatic logic addr_error(input logic [WORD_W-1:0] adr,
                                      input int unsigned       depth);
    logic [WORD_W+1:0] limit;
    limit = (WORD_W+2)'(depth) << BYTE_OFF_W;
    return (adr[BYTE_OFF_W-1:0] != '0) || ({2'b00, adr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: combinational read, one synchronous write port,
// and a synchronous clear of every word while reset is high.
module dmem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_wait_responder.sv
// MEM-stage data-memory responder: inserts LATENCY wait states per access,
// holds the pipeline with stall, and exposes a last-store monitor.
module dmem_wait_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [WORD_W-1:0] dataadr,
  input  logic [WORD_W-1:0] writedata,
  output logic [WORD_W-1:0] readdata,
  output logic              stall,
  output logic              addr_err,
  output logic [WORD_W-1:0] last_wr_adr,
  output logic [WORD_W-1:0] last_wr_data,
  output logic [15:0]       wr_count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

  // Handshake: a request (memread|memwrite) is held stable by the core while
  // stall is high; the access takes effect only in the cycle stall is low
  // with the request still present (the completion cycle).

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req;
  logic              complete_c;
  logic              stall_c;
  logic              bad_adr;
  logic              commit_wr;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] last_wr_adr_q, last_wr_data_q;
  logic [15:0]       wr_count_q;

  assign req     = memread | memwrite;
  assign bad_adr = addr_error(dataadr, DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            complete_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // Flushed by the pipeline: abandon the access without committing.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          complete_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign commit_wr = complete_c & memwrite & ~bad_adr & ~reset;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .reset_i (reset),
    .we_i    (commit_wr),
    .waddr_i (dataadr[AW+1:2]),
    .wdata_i (writedata),
    .raddr_i (dataadr[AW+1:2]),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr_adr_q  <= '0;
      last_wr_data_q <= '0;
      wr_count_q     <= '0;
    end else if (commit_wr) begin
      last_wr_adr_q  <= dataadr;
      last_wr_data_q <= writedata;
      wr_count_q     <= wr_count_q + 16'd1;
    end
  end

  // The array read is pre-write, so a combined read+write returns old data.
  assign readdata     = (complete_c && memread && !bad_adr && !reset) ? arr_rdata : '0;
  assign stall        = stall_c & ~reset;
  assign addr_err     = complete_c & bad_adr & ~reset;
  assign last_wr_adr  = last_wr_adr_q;
  assign last_wr_data = last_wr_data_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Bench for dmem_wait_responder: three instances (LATENCY 2, 0, 3) checked
// every cycle against an access-age model, plus directed literal checks.
module tb_dmem_wait_responder;

  localparam int NI = 3;

  logic        clk;
  logic        rst;
  logic        rd_v   [NI];
  logic        wr_v   [NI];
  logic [31:0] adr_v  [NI];
  logic [31:0] wdat_v [NI];
  logic [31:0] rdata_w [NI];
  logic        stall_w [NI];
  logic        err_w   [NI];
  logic [31:0] la_w    [NI];
  logic [31:0] ld_w    [NI];
  logic [15:0] wc_w    [NI];

  int n_vec  = 0;
  int n_miss = 0;
  bit started = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dmem_wait_responder #(.DEPTH(64), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst), .memread(rd_v[0]), .memwrite(wr_v[0]),
    .dataadr(adr_v[0]), .writedata(wdat_v[0]), .readdata(rdata_w[0]),
    .stall(stall_w[0]), .addr_err(err_w[0]), .last_wr_adr(la_w[0]),
    .last_wr_data(ld_w[0]), .wr_count(wc_w[0]));

  dmem_wait_responder #(.DEPTH(64), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(rst), .memread(rd_v[1]), .memwrite(wr_v[1]),
    .dataadr(adr_v[1]), .writedata(wdat_v[1]), .readdata(rdata_w[1]),
    .stall(stall_w[1]), .addr_err(err_w[1]), .last_wr_adr(la_w[1]),
    .last_wr_data(ld_w[1]), .wr_count(wc_w[1]));

  dmem_wait_responder #(.DEPTH(64), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(rst), .memread(rd_v[2]), .memwrite(wr_v[2]),
    .dataadr(adr_v[2]), .writedata(wdat_v[2]), .readdata(rdata_w[2]),
    .stall(stall_w[2]), .addr_err(err_w[2]), .last_wr_adr(la_w[2]),
    .last_wr_data(ld_w[2]), .wr_count(wc_w[2]));

  function automatic int lat_of(input int k);
    case (k)
      0:       return 2;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit bad_adr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'd256);
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // age = cycles the current request has already been presented; an access
  // completes in the cycle its age equals LATENCY, earlier cycles stall.
  logic [31:0] mem_m [NI][64];
  int          age_m [NI];
  logic [31:0] la_m  [NI];
  logic [31:0] ld_m  [NI];
  logic [15:0] wc_m  [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        for (int j = 0; j < 64; j++) mem_m[k][j] = 32'd0;
        age_m[k] = 0;
        la_m[k]  = 32'd0;
        ld_m[k]  = 32'd0;
        wc_m[k]  = 16'd0;
      end else if ((rd_v[k] || wr_v[k]) && age_m[k] == lat_of(k)) begin
        if (wr_v[k] && !bad_adr(adr_v[k])) begin
          mem_m[k][adr_v[k][7:2]] = wdat_v[k];
          la_m[k] = adr_v[k];
          ld_m[k] = wdat_v[k];
          wc_m[k] = wc_m[k] + 16'd1;
        end
        age_m[k] = 0;
      end else if (rd_v[k] || wr_v[k]) begin
        age_m[k] = age_m[k] + 1;
      end else begin
        age_m[k] = 0;
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NI; k++) begin
        bit          req, done, err;
        logic [31:0] exp_rd;
        req    = rd_v[k] || wr_v[k];
        done   = !rst && req && (age_m[k] == lat_of(k));
        err    = done && bad_adr(adr_v[k]);
        exp_rd = (done && rd_v[k] && !err) ? mem_m[k][adr_v[k][7:2]] : 32'd0;
        chk("stall", k, {31'd0, stall_w[k]}, {31'd0, !rst && req && (age_m[k] < lat_of(k))});
        chk("addr_err", k, {31'd0, err_w[k]}, {31'd0, err});
        chk("readdata", k, rdata_w[k], exp_rd);
        chk("last_wr_adr", k, la_w[k], la_m[k]);
        chk("last_wr_data", k, ld_w[k], ld_m[k]);
        chk("wr_count", k, {16'd0, wc_w[k]}, {16'd0, wc_m[k]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  int          stall_seen;
  int          err_seen;
  logic [31:0] cap_rd;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
    rd_v[k]   = r;
    wr_v[k]   = w;
    adr_v[k]  = a;
    wdat_v[k] = d;
  endtask

  task automatic idle(input int k);
    set_req(k, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Presents a request for LATENCY+1 cycles, recording stalls, error pulses
  // and the completion-cycle readdata; leaves the request on the bus.
  task automatic access(input int k, input bit r, input bit w, input logic [31:0] a,
                        input logic [31:0] d);
    set_req(k, r, w, a, d);
    stall_seen = 0;
    err_seen   = 0;
    cap_rd     = 32'hxxxx_xxxx;
    for (int i = 0; i <= lat_of(k); i++) begin
      @(negedge clk);
      stall_seen += int'(stall_w[k]);
      err_seen   += int'(err_w[k]);
      if (i == lat_of(k)) cap_rd = rdata_w[k];
      step();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    for (int k = 0; k < NI; k++) idle(k);
    step();
    started = 1;
    step();
    step();
    rst = 1'b0;
    step();
    for (int k = 0; k < NI; k++) begin
      chk("rst_wr_count", k, {16'd0, wc_w[k]}, 32'd0);
      chk("rst_last_adr", k, la_w[k], 32'd0);
    end

    // LATENCY=2 store then load
    access(0, 1'b0, 1'b1, 32'd84, 32'd7);
    idle(0);
    chk("t1_stall_cycles", 0, stall_seen, 32'd2);
    chk("t1_last_adr", 0, la_w[0], 32'd84);
    chk("t1_last_data", 0, ld_w[0], 32'd7);
    chk("t1_wr_count", 0, {16'd0, wc_w[0]}, 32'd1);
    step();
    access(0, 1'b1, 1'b0, 32'd84, 32'd0);
    idle(0);
    chk("t2_stall_cycles", 0, stall_seen, 32'd2);
    chk("t2_readdata", 0, cap_rd, 32'd7);
    chk("t2_wr_count", 0, {16'd0, wc_w[0]}, 32'd1);
    // misaligned store at LATENCY=2: stall timing unchanged, one error pulse
    access(0, 1'b0, 1'b1, 32'd86, 32'd99);
    idle(0);
    chk("t4b_stall_cycles", 0, stall_seen, 32'd2);
    chk("t4b_err_pulses", 0, err_seen, 32'd1);
    chk("t4b_wr_count", 0, {16'd0, wc_w[0]}, 32'd1);

    // LATENCY=0 back-to-back stores and loads
    access(1, 1'b0, 1'b1, 32'h50, 32'd5);
    access(1, 1'b0, 1'b1, 32'h54, 32'd9);
    chk("t3_stall_cycles", 1, stall_seen, 32'd0);
    access(1, 1'b1, 1'b0, 32'h50, 32'd0);
    chk("t3_read50", 1, cap_rd, 32'd5);
    access(1, 1'b1, 1'b0, 32'h54, 32'd0);
    chk("t3_read54", 1, cap_rd, 32'd9);
    chk("t3_wr_count", 1, {16'd0, wc_w[1]}, 32'd2);
    access(1, 1'b1, 1'b1, 32'h50, 32'h11);
    chk("t3_rdwr_old", 1, cap_rd, 32'd5);
    access(1, 1'b0, 1'b1, 32'd82, 32'hAA);
    chk("t4_err_82", 1, err_seen, 32'd1);
    access(1, 1'b0, 1'b1, 32'd256, 32'hBB);
    chk("t4_err_256", 1, err_seen, 32'd1);
    access(1, 1'b1, 1'b0, 32'd80, 32'd0);
    chk("t4_read80", 1, cap_rd, 32'h11);
    idle(1);
    chk("t4_wr_count", 1, {16'd0, wc_w[1]}, 32'd3);

    // LATENCY=3 flush after one stall cycle
    set_req(2, 1'b0, 1'b1, 32'h10, 32'hDEAD);
    step();
    idle(2);
    @(negedge clk);
    chk("t5_flush_stall", 2, {31'd0, stall_w[2]}, 32'd0);
    step();
    chk("t5_wr_count", 2, {16'd0, wc_w[2]}, 32'd0);
    access(2, 1'b1, 1'b0, 32'h10, 32'd0);
    idle(2);
    chk("t5_stall_cycles", 2, stall_seen, 32'd3);
    chk("t5_read10", 2, cap_rd, 32'd0);

    // LATENCY=3 reset on the second stall cycle of a store
    access(2, 1'b0, 1'b1, 32'h20, 32'h1234);
    idle(2);
    chk("t6_pre_wr_count", 2, {16'd0, wc_w[2]}, 32'd1);
    set_req(2, 1'b0, 1'b1, 32'h24, 32'h5678);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_stall", 2, {31'd0, stall_w[2]}, 32'd0);
    step();
    rst = 1'b0;
    idle(2);
    step();
    for (int k = 0; k < NI; k++) begin
      chk("t6_wr_count", k, {16'd0, wc_w[k]}, 32'd0);
      chk("t6_last_adr", k, la_w[k], 32'd0);
      chk("t6_last_data", k, ld_w[k], 32'd0);
    end
    access(2, 1'b1, 1'b0, 32'h20, 32'd0);
    idle(2);
    chk("t6_read20", 2, cap_rd, 32'd0);
    access(0, 1'b1, 1'b0, 32'd84, 32'd0);
    idle(0);
    chk("t6_read84", 0, cap_rd, 32'd0);

    // wr_count wrap on the LATENCY=0 instance
    for (int i = 0; i < 65535; i++) begin
      set_req(1, 1'b0, 1'b1, 32'(4 * (i % 64)), 32'(i));
      step();
    end
    idle(1);
    chk("wrap_ffff", 1, {16'd0, wc_w[1]}, 32'h0000_FFFF);
    access(1, 1'b0, 1'b1, 32'h8, 32'hCAFE);
    idle(1);
    chk("wrap_zero", 1, {16'd0, wc_w[1]}, 32'd0);
    chk("wrap_last_data", 1, ld_w[1], 32'hCAFE);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
